alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier controller that computes the low WIDTH bits of a product by sequencing the shared 64-bit ALU through repeated ADD operations.
- Sits beside the execute stage and serves LEGv8 MUL.
- Requests the ALU through a req/grant handshake with the datapath arbiter.
- Holds the result until the next operation.

Parameters:
- WIDTH, 64, operand, product and ALU datapath width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a multiply; sampled only in IDLE.
- MULTIPLICAND  input  WIDTH  operand A; sampled with an accepted START.
- MULTIPLIER  input  WIDTH  operand B; sampled with an accepted START.
- BUSY  output  1  high in ITER and FINISH.
- DONE  output  1  one-cycle pulse in FINISH.
- PRODUCT  output  WIDTH  registered low WIDTH bits of the product; held until the next FINISH.
- PRODUCT_ZERO  output  1  registered (PRODUCT == 0).
- ALU_REQ  output  1  ALU request; high in every ITER cycle.
- ALU_GNT  input  1  arbiter grant; the ALU result is consumed only when ALU_REQ && ALU_GNT.
- ALU_A  output  WIDTH  ALU operand A.
- ALU_B  output  WIDTH  ALU operand B.
- ALU_CONTROL  output  4  ALU opcode; 4'b0010 = ADD.
- ALU_RESULT  input  WIDTH  combinational ALU result for the current ALU_A, ALU_B and ALU_CONTROL.

Behaviour:
- Internal registers:
  - acc (WIDTH), the running sum.
  - mcand (WIDTH), the multiplicand, shifted left each iteration.
  - mplier (WIDTH), the multiplier, shifted right each iteration.
  - cnt (CNT_W), the iteration count.
  - state, one of IDLE, ITER, FINISH.
- Reset, and every reset mid-operation:
  - state=IDLE, acc/mcand/mplier/cnt=0.
  - PRODUCT=0, PRODUCT_ZERO=1.
  - BUSY=0, DONE=0, ALU_REQ=0.
  - A multiply in flight is abandoned and no DONE is produced.
  - RESET has priority over START and GNT in the same cycle.
- IDLE:
  - Outputs ALU_A=0, ALU_B=0, ALU_CONTROL=4'b0000.
  - On START: load mcand=MULTIPLICAND, mplier=MULTIPLIER, acc=0, cnt=0.
  - Next state is ITER if MULTIPLIER!=0, else FINISH (product 0, zero ALU requests).
- ITER:
  - Outputs ALU_REQ=1, ALU_A=acc, ALU_B = mplier[0] ? mcand : 0, ALU_CONTROL=4'b0010.
  - If ALU_GNT: acc<=ALU_RESULT (mod 2^WIDTH, no carry out), mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Exit to FINISH after that update when (mplier>>1)==0 or cnt==WIDTH-1.
  - If !ALU_GNT: all registers hold, stay in ITER, ALU_REQ stays high, ALU_A/ALU_B/ALU_CONTROL stay stable.
- FINISH:
  - PRODUCT<=acc and PRODUCT_ZERO<=(acc==0), registered on entry so they are visible in the cycle after FINISH.
  - DONE=1 for exactly this cycle.
  - ALU outputs as in IDLE.
  - Next state is IDLE unconditionally.
  - START in FINISH is ignored.
- START while BUSY=1 is ignored; operands are not re-sampled.
- Outputs in IDLE/FINISH: BUSY, DONE and ALU_REQ are combinational decodes of state (glitch-free, from registered state); ALU_A/ALU_B/ALU_CONTROL are defined for all states.
- Latency: with k = index of the MSB set in MULTIPLIER + 1 (k=0 for zero) and GNT held high:
  - START accepted at edge 0.
  - ITER occupies cycles 1..k.
  - DONE is high in cycle k+1.
  - The new PRODUCT is valid from cycle k+2.
  - Each GNT-low ITER cycle adds 1.
- Result is the low WIDTH bits of the product, identical for signed and unsigned operands. No overflow flag.

Test Plan:
- MULTIPLICAND=3, MULTIPLIER=5, GNT=1 -> ALU_REQ high cycles 1-3, ALU_B sequence 3,0,12, DONE in cycle 4, PRODUCT=15, PRODUCT_ZERO=0.
- MULTIPLIER=0, MULTIPLICAND=0xDEAD -> ALU_REQ never high, DONE in cycle 1, PRODUCT=0, PRODUCT_ZERO=1.
- Both operands 0xFFFF_FFFF_FFFF_FFFF -> 64 ITER cycles, DONE in cycle 65, PRODUCT=0x0000_0000_0000_0001; also -7 × 6 -> PRODUCT=0xFFFF_FFFF_FFFF_FFD6.
- 7 × 9 with GNT low in cycles 2 and 3 -> ALU_A/ALU_B/ALU_CONTROL stable across the stall, DONE in cycle 7 (5+2), PRODUCT=63.
- START with 2×3 then START pulsed again with 4×4 in cycle 1 -> second START ignored, PRODUCT=6; then RESET asserted mid-ITER of 0x100×0x100 -> next cycle BUSY=0, PRODUCT=0, no DONE.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier that drives the shared ALU with ADD operations
// and returns the low WIDTH bits of the product.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for START; ALU outputs parked at zero
// S_ITER   | one partial-product add per granted ALU cycle
// S_FINISH | DONE pulse; accumulator copied into PRODUCT at end of cycle
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic             product_zero_o,
  output logic             alu_req_o,
  input  logic             alu_gnt_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             product_zero_q, product_zero_d;

  logic             busy, done, alu_req;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] mplier_shr;

  assign mplier_shr = mplier_q >> 1;

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    cnt_d          = cnt_q;
    product_d      = product_q;
    product_zero_d = product_zero_q;
    busy           = 1'b0;
    done           = 1'b0;
    alu_req        = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_control    = ALU_NOP;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          acc_d    = '0;
          cnt_d    = '0;
          // A zero multiplier skips the ALU entirely; acc is already zero.
          state_d  = (multiplier_i != '0) ? S_ITER : S_FINISH;
        end
      end

      S_ITER: begin
        busy        = 1'b1;
        alu_req     = 1'b1;
        alu_a       = acc_q;
        alu_b       = mplier_q[0] ? mcand_q : '0;
        alu_control = ALU_ADD;
        if (alu_gnt_i) begin
          acc_d    = alu_result_i;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shr;
          cnt_d    = cnt_q + 1'b1;
          // Stop as soon as no multiplier bits remain, so latency tracks the MSB.
          if ((mplier_shr == '0) || (cnt_q == CNT_LAST)) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        busy           = 1'b1;
        done           = 1'b1;
        product_d      = acc_q;
        product_zero_d = (acc_q == '0);
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      cnt_q          <= '0;
      product_q      <= '0;
      product_zero_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      cnt_q          <= cnt_d;
      product_q      <= product_d;
      product_zero_q <= product_zero_d;
    end
  end

  assign busy_o         = busy;
  assign done_o         = done;
  assign alu_req_o      = alu_req;
  assign alu_a_o        = alu_a;
  assign alu_b_o        = alu_b;
  assign alu_control_o  = alu_control;
  assign product_o      = product_q;
  assign product_zero_o = product_zero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU plus a multiplication reference.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, gnt;
  logic [63:0] mcand_in, mplier_in;
  logic        busy, done, product_zero, alu_req;
  logic [63:0] product, alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;

  int errors = 0;
  int checks = 0;

  int          obs_done_cyc, obs_iters, obs_stalls, obs_seq_err, obs_unstable;
  logic [63:0] obs_prod;
  logic        obs_pz, obs_busy_after;
  logic [63:0] obs_b [0:3];

  always #5 clk = ~clk;

  // Anything other than ADD yields a deliberately wrong value.
  assign alu_result = (alu_control == 4'b0010) ? (alu_a + alu_b) : ~(alu_a + alu_b);

  alu_mul_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .multiplicand_i(mcand_in), .multiplier_i(mplier_in),
    .busy_o(busy), .done_o(done), .product_o(product), .product_zero_o(product_zero),
    .alu_req_o(alu_req), .alu_gnt_i(gnt), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_control_o(alu_control), .alu_result_i(alu_result)
  );

  function automatic int model_k(input logic [63:0] b);
    int k = 0;
    for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Runs one multiply from START to the cycle after DONE and records observations.
  // stall_mode: 0 grant always, 1 random grant, 2 grant low where stall_mask[cycle].
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input int stall_mode,
                        input logic [31:0] stall_mask, input int restart_cyc,
                        input logic [63:0] ra, input logic [63:0] rb);
    int cyc, it;
    logic [63:0] macc, pa, pb, part;
    logic [3:0] pc;
    bit pstall, fin;
    obs_done_cyc = -1; obs_iters = 0; obs_stalls = 0; obs_seq_err = 0; obs_unstable = 0;
    obs_prod = 'x; obs_pz = 1'bx; obs_busy_after = 1'bx;
    for (int i = 0; i < 4; i++) obs_b[i] = 'x;
    mcand_in = a; mplier_in = b; start = 1'b1; gnt = 1'b1;
    @(posedge clk); #1;
    cyc = 1; it = 0; macc = '0; pstall = 0; fin = 0; pa = '0; pb = '0; pc = '0;
    while (!fin && cyc < 300) begin
      if (cyc == restart_cyc) begin
        start = 1'b1; mcand_in = ra; mplier_in = rb;
      end else begin
        start = 1'b0;
      end
      case (stall_mode)
        1:       gnt = ($urandom_range(0, 3) != 0);
        2:       gnt = (cyc < 32) ? !stall_mask[cyc] : 1'b1;
        default: gnt = 1'b1;
      endcase
      if (pstall && (alu_a !== pa || alu_b !== pb || alu_control !== pc)) obs_unstable++;
      if (alu_req) begin
        if (gnt) begin
          part = (it < 64 && b[it]) ? (a << it) : 64'd0;
          if (alu_a !== macc || alu_b !== part || alu_control !== 4'b0010) obs_seq_err++;
          if (it < 4) obs_b[it] = alu_b;
          macc = macc + part;
          it++;
          obs_iters++;
        end else begin
          obs_stalls++;
        end
      end
      pstall = alu_req && !gnt;
      pa = alu_a; pb = alu_b; pc = alu_control;
      if (done) begin
        obs_done_cyc = cyc;
        start = 1'b0;
        @(posedge clk); #1;
        obs_prod = product; obs_pz = product_zero; obs_busy_after = busy;
        fin = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0; gnt = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; gnt = 1'b1; mcand_in = '0; mplier_in = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (alu_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", alu_req); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
    checks++; if (product_zero !== 1'b1) begin errors++; $display("FAIL reset_pzero: got %b expected 1", product_zero); end
    checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_control !== 4'd0) begin
      errors++; $display("FAIL reset_alu_outs: got a=%h b=%h c=%h expected all 0", alu_a, alu_b, alu_control);
    end
  endtask

  task automatic test_basic();
    do_mul(64'd3, 64'd5, 0, 32'd0, -1, '0, '0);
    checks++; if (obs_done_cyc !== 4) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 4", obs_done_cyc); end
    checks++; if (obs_iters !== 3) begin errors++; $display("FAIL basic_req_cycles: got %0d expected 3", obs_iters); end
    checks++; if (obs_b[0] !== 64'd3 || obs_b[1] !== 64'd0 || obs_b[2] !== 64'd12) begin
      errors++; $display("FAIL basic_alu_b_seq: got %0d,%0d,%0d expected 3,0,12", obs_b[0], obs_b[1], obs_b[2]);
    end
    checks++; if (obs_prod !== 64'd15) begin errors++; $display("FAIL basic_product: got %0d expected 15", obs_prod); end
    checks++; if (obs_pz !== 1'b0) begin errors++; $display("FAIL basic_pzero: got %b expected 0", obs_pz); end
    checks++; if (obs_seq_err !== 0) begin errors++; $display("FAIL basic_alu_ops: got %0d bad cycles expected 0", obs_seq_err); end
  endtask

  task automatic test_zero_multiplier();
    do_mul(64'hDEAD, 64'd0, 0, 32'd0, -1, '0, '0);
    checks++; if (obs_iters + obs_stalls !== 0) begin errors++; $display("FAIL zero_req: got %0d req cycles expected 0", obs_iters + obs_stalls); end
    checks++; if (obs_done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", obs_done_cyc); end
    checks++; if (obs_prod !== 64'd0) begin errors++; $display("FAIL zero_product: got %h expected 0", obs_prod); end
    checks++; if (obs_pz !== 1'b1) begin errors++; $display("FAIL zero_pzero: got %b expected 1", obs_pz); end
  endtask

  task automatic test_wrap();
    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'd0, -1, '0, '0);
    checks++; if (obs_iters !== 64) begin errors++; $display("FAIL ones_iters: got %0d expected 64", obs_iters); end
    checks++; if (obs_done_cyc !== 65) begin errors++; $display("FAIL ones_done_cycle: got %0d expected 65", obs_done_cyc); end
    checks++; if (obs_prod !== 64'd1) begin errors++; $display("FAIL ones_product: got %h expected 1", obs_prod); end
    do_mul(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 0, 32'd0, -1, '0, '0);
    checks++; if (obs_prod !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL neg_product: got %h expected ffffffffffffffd6", obs_prod); end
    checks++; if (obs_done_cyc !== 4) begin errors++; $display("FAIL neg_done_cycle: got %0d expected 4", obs_done_cyc); end
  endtask

  task automatic test_stall();
    do_mul(64'd7, 64'd9, 2, 32'b1100, -1, '0, '0);
    checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", obs_unstable); end
    checks++; if (obs_stalls !== 2) begin errors++; $display("FAIL stall_count: got %0d expected 2", obs_stalls); end
    checks++; if (obs_done_cyc !== 7) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 7", obs_done_cyc); end
    checks++; if (obs_prod !== 64'd63) begin errors++; $display("FAIL stall_product: got %0d expected 63", obs_prod); end
  endtask

  task automatic test_start_ignored();
    do_mul(64'd2, 64'd3, 0, 32'd0, 1, 64'd4, 64'd4);
    checks++; if (obs_prod !== 64'd6) begin errors++; $display("FAIL busy_start_product: got %0d expected 6", obs_prod); end
    checks++; if (obs_done_cyc !== 3) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 3", obs_done_cyc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_relaunch: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dones;
    mcand_in = 64'h100; mplier_in = 64'h100; start = 1'b1; gnt = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (alu_req !== 1'b1) begin errors++; $display("FAIL midrst_pre_iter: got req=%b expected 1", alu_req); end
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || alu_req !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy=%b req=%b expected 0 0", busy, alu_req); end
    checks++; if (product !== 64'd0 || product_zero !== 1'b1) begin
      errors++; $display("FAIL midrst_product: got %h pz=%b expected 0 pz=1", product, product_zero);
    end
    dones = 0;
    repeat (15) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dones); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, exp;
    int k;
    for (int n = 0; n < 25; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (n == 3) b = 64'd0;
      exp = a * b;
      k = model_k(b);
      do_mul(a, b, 1, 32'd0, -1, '0, '0);
      checks++; if (obs_prod !== exp) begin errors++; $display("FAIL rand_product[%0d]: got %h expected %h", n, obs_prod, exp); end
      checks++; if (obs_pz !== (exp == 64'd0)) begin errors++; $display("FAIL rand_pzero[%0d]: got %b expected %b", n, obs_pz, exp == 64'd0); end
      checks++; if (obs_iters !== k) begin errors++; $display("FAIL rand_iters[%0d]: got %0d expected %0d", n, obs_iters, k); end
      checks++; if (obs_done_cyc !== k + 1 + obs_stalls) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, obs_done_cyc, k + 1 + obs_stalls);
      end
      checks++; if (obs_seq_err !== 0 || obs_unstable !== 0) begin
        errors++; $display("FAIL rand_alu_ops[%0d]: got %0d bad %0d unstable expected 0 0", n, obs_seq_err, obs_unstable);
      end
      checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL rand_idle_after[%0d]: got busy=%b expected 0", n, obs_busy_after); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_multiplier();
    test_wrap();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
